disparity_delay_line: RTL
=========================

Name: disparity_delay_line

Overview:
- Parametrised, stallable delay line for the disparity post-processing pipeline.
- Carries a disparity word, sideband flags (e.g. homogeneity) and a valid bit through a fixed delay of LINE_W*N_LINES+EXTRA enabled cycles, so pure disparity stays aligned with the window-centre pixel of downstream filters.
- Generalises the fixed 8-bit / 640x5+5 delay: configurable widths and geometry, clock-enable stall, synchronous reset, and output masking until the line has primed.

Parameters:
DATA_W, 8, width of disparity word
FLAG_W, 1, width of sideband flag bus
LINE_W, 640, pixels per image line
N_LINES, 5, number of whole lines of delay
EXTRA, 5, additional pixel delay after the whole lines
DELAY, LINE_W*N_LINES+EXTRA (derived localparam), total delay in enabled cycles; must be >= 2

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  synchronous active-low reset
i_en  input  1  advance enable; 0 = stall, all state holds
i_data  input  DATA_W  disparity in
i_flags  input  FLAG_W  sideband flags in
i_valid  input  1  valid in
o_data  output  DATA_W  delayed disparity
o_flags  output  FLAG_W  delayed flags
o_valid  output  1  delayed valid, masked until primed
o_primed  output  1  1 once DELAY enabled cycles have elapsed since reset

Behaviour:
- Reset: the design samples i_rst_n=0 on the rising edge of i_clk. On that edge, o_data=0, o_flags=0, o_valid=0, o_primed=0, and the write/read pointer and fill counter go to 0. Storage contents are not cleared.
- Reset has priority over i_en.
- Enabled edges: only edges with i_rst_n=1 and i_en=1 count. Number them k=0,1,2,... from the last reset.
- Transfer function: after enabled edge k with k>=DELAY, the outputs are {o_data,o_flags,o_valid} = {i_data,i_flags,i_valid} sampled at enabled edge k-DELAY.
- Pre-prime masking: after enabled edge k with k<DELAY, o_valid=0. o_data and o_flags are 0 there; stale storage must never appear.
- Stall: an edge with i_en=0 changes no pointer, counter, storage or output. Inputs presented during a stall are ignored.
- Fill counter: counts enabled edges and saturates at DELAY.
- o_primed: goes 1 at enabled edge k=DELAY-1, so it is already 1 when the first real data (k=DELAY) appears. It stays 1 until reset.
- Storage: a single-port-pattern circular buffer (inferred block RAM, depth DELAY-1 or DELAY) plus output register.
  - Pointer wraps to 0 after the last address.
  - Read-before-write on the same address must yield the old data.
  - No per-stage shift registers for widths above 1.
- Reset mid-operation: all data in flight is discarded. Outputs are masked again for DELAY enabled edges; o_primed drops to 0.
- Throughput: one word per enabled cycle, no back-pressure output. Upstream must stall via i_en.
- Widths: all fields are carried bit-exact, with no arithmetic on the data. The counter and pointer are $clog2(DELAY+1) bits.
- Simultaneous i_rst_n=0 and i_en=1: reset wins and no write occurs.

Test Plan:
- Small geometry LINE_W=4, N_LINES=2, EXTRA=1 (DELAY=9); release reset, i_en=1, i_data=k+1, i_valid=1 on every cycle -> o_valid=0 and o_data=0 for enabled edges 0..8; o_primed=1 from edge 8; at edge 9 o_data=1, at edge 20 o_data=12.
- Same config, i_en toggling 1,0,1,0 with i_data changing every cycle -> o_data sequence equals the sequence of values sampled on enabled edges only, delayed by 9 enabled edges; outputs constant on stalled edges.
- Pre-fill storage with 0xAA, assert i_rst_n=0 for one edge mid-stream, then stream 0x01.. -> o_valid=0 and o_data=0 for 9 enabled edges, never 0xAA; o_primed reasserts at edge 8.
- Same config, i_valid pattern 1,0,0,1 with i_flags=1,0,1,0 -> o_valid and o_flags reproduce the same patterns exactly 9 enabled edges later.
- Default config (DELAY=3205), 4000-cycle random stream -> o_data matches the scoreboard input from 3205 enabled edges earlier; first o_valid=1 at enabled edge 3205; pointer wrap at least once with no mismatch.
- Reset asserted together with i_en=1 on the same edge -> no write, outputs 0, fill counter 0 on the next cycle.

Source files
------------

// File: rtl/disparity_delay_line_if.sv
// Stream bundle for the disparity delay line: disparity word, sideband flags,
// valid and advance enable on the way in; the delayed copies and the primed
// indication on the way out.
interface disparity_delay_line_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FLAG_W = 1
);
    logic              i_en;
    logic [DATA_W-1:0] i_data;
    logic [FLAG_W-1:0] i_flags;
    logic              i_valid;
    logic [DATA_W-1:0] o_data;
    logic [FLAG_W-1:0] o_flags;
    logic              o_valid;
    logic              o_primed;

    // Upstream / environment side
    modport master (
        output i_en,
        output i_data,
        output i_flags,
        output i_valid,
        input  o_data,
        input  o_flags,
        input  o_valid,
        input  o_primed
    );

    // Delay line side
    modport slave (
        input  i_en,
        input  i_data,
        input  i_flags,
        input  i_valid,
        output o_data,
        output o_flags,
        output o_valid,
        output o_primed
    );
endinterface

// File: rtl/disparity_delay_line.sv
// Stallable delay line keeping disparity aligned with the window-centre pixel
// of downstream filters. Delay is LINE_W*N_LINES+EXTRA enabled cycles (must be
// at least 2). Implemented as a DELAY-deep read-first circular buffer followed
// by an output register; the output register is forced to zero until the
// buffer has been completely written since reset, so stale storage never leaks.
module disparity_delay_line #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned FLAG_W  = 1,
    parameter int unsigned LINE_W  = 640,
    parameter int unsigned N_LINES = 5,
    parameter int unsigned EXTRA   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    disparity_delay_line_if.slave bus
);

    localparam int unsigned DELAY  = LINE_W * N_LINES + EXTRA;
    localparam int unsigned CNT_W  = $clog2(DELAY + 1);
    localparam int unsigned WORD_W = DATA_W + FLAG_W + 1;

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DELAY);

    // Word layout: {data, flags, valid}
    logic [WORD_W-1:0] mem_q [DELAY];

    logic [CNT_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              full;

    // Next-state: advance pointer, saturate fill count, load masked read data
    always_comb begin
        wr_word = {bus.i_data, bus.i_flags, bus.i_valid};
        rd_word = mem_q[ptr_q];
        full    = (fill_q == FULL_CNT);
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        out_d   = out_q;
        if (bus.i_en) begin
            ptr_d  = (ptr_q == LAST_ADDR) ? '0 : ptr_q + CNT_W'(1);
            fill_d = full ? fill_q : fill_q + CNT_W'(1);
            // Slot at ptr_q holds the word written exactly DELAY enabled edges ago
            // only once every slot has been written since reset.
            out_d  = full ? rd_word : '0;
        end
    end

    // Control and output registers; reset overrides enable
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q  <= '0;
            fill_q <= '0;
            out_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    // Storage write; contents deliberately survive reset, masking covers them
    always_ff @(posedge i_clk) begin
        if (i_rst_n && bus.i_en) begin
            mem_q[ptr_q] <= wr_word;
        end
    end

    assign bus.o_data   = out_q[WORD_W-1 -: DATA_W];
    assign bus.o_flags  = out_q[FLAG_W:1];
    assign bus.o_valid  = out_q[0];
    assign bus.o_primed = full;

endmodule
